// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the fifo_dc write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Upper bits of gray beyond width must be zero; result is zero-extended.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic        acc;
    logic [31:0] bin;
    acc = 1'b0;
    bin = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i < width) begin
        acc    = acc ^ gray[i];
        bin[i] = acc;
      end
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Two-flop synchronizer bringing the read-side gray count into wr_clock.
module gray_sync #(
  parameter int W = 10
) (
  input  logic         wr_clock,
  input  logic         n_rst,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] gray_out
);

  logic [W-1:0] meta_q, sync_q;

  always_ff @(posedge wr_clock) begin
    if (!n_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= gray_in;
      sync_q <= meta_q;
    end
  end

  assign gray_out = sync_q;

endmodule

// File: rtl/fifo_dc_wr_arbiter.sv
// Round-robin, burst-locking write arbiter for a shared fifo_dc; tags words
// with source ID and throttles on a conservative occupancy estimate.
module fifo_dc_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 8,
  parameter int FIFO_SIZE = 512,
  parameter int BURST_LEN = 16,
  localparam int ID_BITW  = $clog2(NUM_REQ),
  localparam int CNT_BITW = $clog2(FIFO_SIZE) + 1
) (
  input  logic                         wr_clock,
  input  logic                         n_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [CNT_BITW-1:0]          rd_count_gray,
  output logic                         fifo_wr_en,
  output logic [ID_BITW+BIT_WIDTH-1:0] fifo_wr_data,
  output logic [CNT_BITW-1:0]          level,
  output logic                         busy
);

  localparam int BC_BITW = $clog2(BURST_LEN + 1);

  arb_state_t                   state_q, state_d;
  logic [ID_BITW-1:0]           rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [BC_BITW-1:0]           burst_cnt_q, burst_cnt_d;
  logic [CNT_BITW-1:0]          wr_count_q, wr_count_d, level_q, level_d;
  logic                         fifo_wr_en_q, fifo_wr_en_d;
  logic [ID_BITW+BIT_WIDTH-1:0] fifo_wr_data_q, fifo_wr_data_d;

  logic [CNT_BITW-1:0] rd_gray_sync, rd_count_bin;
  logic [ID_BITW-1:0]  pick_id, acc_id;
  logic                pick_valid, accept, full;
  int                  idx;

  // Explicit compare so non-power-of-two NUM_REQ wraps correctly.
  function automatic logic [ID_BITW-1:0] wrap_inc(input logic [ID_BITW-1:0] p);
    return (p == ID_BITW'(NUM_REQ - 1)) ? '0 : p + ID_BITW'(1);
  endfunction

  gray_sync #(.W(CNT_BITW)) u_rd_sync (
    .wr_clock (wr_clock),
    .n_rst    (n_rst),
    .gray_in  (rd_count_gray),
    .gray_out (rd_gray_sync)
  );

  assign rd_count_bin = CNT_BITW'(gray2bin(32'(rd_gray_sync), CNT_BITW));
  assign full         = (level_q == CNT_BITW'(FIFO_SIZE));

  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_BITW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (n_rst && !full) begin
      if (state_q == IDLE) begin
        if (pick_valid) req_ready[pick_id] = 1'b1;
      end else begin
        req_ready[owner_q] = req_valid[owner_q];
      end
    end
  end

  assign accept = |(req_valid & req_ready);
  assign acc_id = (state_q == IDLE) ? pick_id : owner_q;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    burst_cnt_d    = burst_cnt_q;
    wr_count_d     = wr_count_q + CNT_BITW'(accept);
    level_d        = wr_count_d - rd_count_bin;
    fifo_wr_en_d   = accept;
    fifo_wr_data_d = accept ? {acc_id, req_data[acc_id*BIT_WIDTH +: BIT_WIDTH]} : fifo_wr_data_q;
    if (state_q == IDLE) begin
      if (accept) begin
        owner_d     = acc_id;
        burst_cnt_d = BC_BITW'(1);
        if (BURST_LEN == 1) rr_ptr_d = wrap_inc(acc_id);
        else                state_d  = BURST;
      end
    end else begin
      if (accept) begin
        burst_cnt_d = burst_cnt_q + BC_BITW'(1);
        if (burst_cnt_d == BC_BITW'(BURST_LEN)) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_inc(owner_q);
        end
      end else if (!req_valid[owner_q]) begin
        // A stall on full keeps the lock; only a missing word releases it.
        state_d  = IDLE;
        rr_ptr_d = wrap_inc(owner_q);
      end
    end
  end

  always_ff @(posedge wr_clock) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      burst_cnt_q    <= '0;
      wr_count_q     <= '0;
      level_q        <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      burst_cnt_q    <= burst_cnt_d;
      wr_count_q     <= wr_count_d;
      level_q        <= level_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
    end
  end

  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign level        = level_q;
  assign busy         = (state_q == BURST);

endmodule
